// File: rtl/cke_sched.sv
// Multi-channel clock-enable scheduler: per-channel tick dividers feeding a round-robin strobe arbiter.
// Optional sticky overrun flags are built only when CKE_SCHED_OVF_EN is defined.
module cke_sched #(
   parameter int N_CH  = 4,
   parameter int DIV_W = 16,
   localparam int CH_W = $clog2(N_CH)
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             tick,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_os,
   output logic [N_CH-1:0]  cke_out,
   output logic [N_CH-1:0]  busy
`ifdef CKE_SCHED_OVF_EN
   ,
   output logic [N_CH-1:0]  ovf
`endif
);

   logic [N_CH-1:0][DIV_W-1:0] r_cnt;
   logic [N_CH-1:0][DIV_W-1:0] r_div;
   logic [N_CH-1:0]            r_os;
   logic [N_CH-1:0]            r_active;
   logic [N_CH-1:0]            r_pend;
   logic [CH_W-1:0]            r_rr;
   logic [N_CH-1:0]            r_cke;

   logic [N_CH-1:0]            w_cfg_hit;
   logic [N_CH-1:0]            w_exp;
   logic [N_CH-1:0]            w_gnt;
   logic [CH_W-1:0]            w_sel;
   logic                       w_any;

   // Scan from the highest offset down so the nearest pending channel at or after r_rr wins.
   always_comb begin
      int idx;
      idx   = 0;
      w_sel = '0;
      w_any = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = (int'(r_rr) + k) % N_CH;
         if (r_pend[idx]) begin
            w_sel = CH_W'(idx);
            w_any = 1'b1;
         end
      end
   end

   assign w_gnt = w_any ? (N_CH'(1) << w_sel) : '0;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign w_cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
      assign w_exp[i]     = tick && r_active[i] && (r_cnt[i] == '0) && !w_cfg_hit[i];

      always_ff @(posedge clk or negedge rst_) begin
         if (!rst_) begin
            r_cnt[i]    <= '0;
            r_div[i]    <= '0;
            r_os[i]     <= 1'b0;
            r_active[i] <= 1'b0;
            r_pend[i]   <= 1'b0;
         end else if (w_cfg_hit[i]) begin
            r_div[i]    <= cfg_div;
            r_os[i]     <= cfg_os;
            r_cnt[i]    <= cfg_div - DIV_W'(1);
            r_active[i] <= (cfg_div != '0);
            r_pend[i]   <= 1'b0;
         end else begin
            if (tick && r_active[i]) begin
               if (r_cnt[i] != '0) begin
                  r_cnt[i] <= r_cnt[i] - DIV_W'(1);
               end else begin
                  r_cnt[i] <= r_div[i] - DIV_W'(1);
                  if (r_os[i]) r_active[i] <= 1'b0;
               end
            end
            // A fresh expiry outranks the grant so a back-to-back period is never lost.
            if (w_exp[i])      r_pend[i] <= 1'b1;
            else if (w_gnt[i]) r_pend[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_rr  <= '0;
         r_cke <= '0;
      end else begin
         r_cke <= w_gnt;
         if (w_any) r_rr <= (w_sel == CH_W'(N_CH - 1)) ? '0 : w_sel + CH_W'(1);
      end
   end

   assign cke_out = r_cke;
   assign busy    = r_active | r_pend;

`ifdef CKE_SCHED_OVF_EN
   logic [N_CH-1:0] r_ovf;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) r_ovf <= '0;
      else       r_ovf <= r_ovf | (w_exp & r_pend & ~w_gnt);
   end

   assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_cke_sched.sv
// Directed bench for cke_sched: divider timing, one-shot, round-robin order, abort, reset, overrun.
module tb_cke_sched;
   localparam int N_CH  = 4;
   localparam int DIV_W = 16;

   logic             clk = 1'b0;
   logic             rst_;
   logic             tick;
   logic             cfg_we;
   logic [1:0]       cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_os;
   logic [N_CH-1:0]  cke_out;
   logic [N_CH-1:0]  busy;
`ifdef CKE_SCHED_OVF_EN
   logic [N_CH-1:0]  ovf;
`endif

   int n_run  = 0;
   int n_fail = 0;

   cke_sched #(.N_CH(N_CH), .DIV_W(DIV_W)) dut (
      .clk(clk), .rst_(rst_), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .cfg_os(cfg_os), .cke_out(cke_out), .busy(busy)
`ifdef CKE_SCHED_OVF_EN
      , .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input logic t);
      tick = t;
      @(posedge clk); #1;
      tick = 1'b0;
   endtask

   task automatic cfg(input int ch, input int dv, input logic os);
      cfg_we  = 1'b1;
      cfg_ch  = 2'(ch);
      cfg_div = DIV_W'(dv);
      cfg_os  = os;
      @(posedge clk); #1;
      cfg_we  = 1'b0;
   endtask

   task automatic do_reset();
      rst_ = 1'b0;
      @(posedge clk); #1;
      rst_ = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst_ && ($countones(cke_out) > 1)) begin
         n_run++;
         n_fail++;
         $display("FAIL onehot got=%b exp=at most one bit", cke_out);
      end
   end

   initial begin
      int pulses;
      logic [N_CH-1:0] e;
      rst_ = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_os = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cke", 32'(cke_out), 0);
      chk("rst_busy", 32'(busy), 0);
`ifdef CKE_SCHED_OVF_EN
      chk("rst_ovf", 32'(ovf), 0);
`endif
      rst_ = 1'b1;

      // ch0 div=3 periodic, tick every cycle
      cfg(0, 3, 1'b0);
      for (int n = 1; n <= 10; n++) begin
         cyc(1'b1);
         chk($sformatf("div3_n%0d", n), 32'(cke_out), (n >= 4 && (n - 4) % 3 == 0) ? 1 : 0);
      end
      cfg(0, 0, 1'b0);

      // ch2 div=2 one-shot, tick every 5th cycle
      cfg(2, 2, 1'b1);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(i % 5 == 0);
         if (cke_out[2]) pulses++;
         if (i == 6) chk("os_pulse", 32'(cke_out), 4);
      end
      chk("os_count", 32'(pulses), 1);
      chk("os_busy", 32'(busy), 0);

      // async reset between edges while strobes are pending
      for (int c = 0; c < 4; c++) cfg(c, 1, 1'b0);
      cyc(1'b1);
      cyc(1'b0);
      chk("pre_rst_cke", 32'(cke_out), 8);
      #2 rst_ = 1'b0;
      #1;
      chk("arst_cke", 32'(cke_out), 0);
      chk("arst_busy", 32'(busy), 0);
`ifdef CKE_SCHED_OVF_EN
      chk("arst_ovf", 32'(ovf), 0);
`endif
      @(posedge clk); #1;
      rst_ = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1);
         chk("post_rst_cke", 32'(cke_out), 0);
         chk("post_rst_busy", 32'(busy), 0);
      end

      // four-way contention, two rounds, each starting from ch0
      for (int c = 0; c < 4; c++) cfg(c, 1, 1'b0);
      for (int r = 0; r < 2; r++) begin
         cyc(1'b1);
         chk("rr_tick", 32'(cke_out), 0);
         for (int k = 0; k < 4; k++) begin
            cyc(1'b0);
            chk($sformatf("rr%0d_k%0d", r, k), 32'(cke_out), 32'(1) << k);
         end
         cyc(1'b0);
         chk("rr_idle", 32'(cke_out), 0);
      end

      // abort ch1 while pending
      cyc(1'b1);
      cfg(1, 0, 1'b0);
      chk("abort_cke0", 32'(cke_out), 1);
      chk("abort_busy", 32'(busy), 4'b1101);
      e = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0);
         chk($sformatf("abort_k%0d", k), 32'(cke_out), 32'(e));
         e = {e[N_CH-2:0], 1'b0};
      end

      // overrun: grant-plus-expiry on ch0 keeps ovf clear, then 4-way overrun
      do_reset();
      cfg(0, 1, 1'b0);
      cfg(1, 2, 1'b0);
      cyc(1'b1);
      chk("ov_a", 32'(cke_out), 0);
      cyc(1'b1);
      chk("ov_b", 32'(cke_out), 1);
      cyc(1'b0);
      chk("ov_c", 32'(cke_out), 2);
      cyc(1'b0);
      chk("ov_d", 32'(cke_out), 1);
`ifdef CKE_SCHED_OVF_EN
      chk("ov_clear", 32'(ovf), 0);
`endif
      cyc(1'b0);
      chk("ov_e", 32'(cke_out), 0);
      for (int c = 0; c < 4; c++) cfg(c, 1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         cyc(1'b1);
         chk($sformatf("ov4_k%0d", k), 32'(cke_out), (k == 1) ? 0 : (32'(1) << ((k - 1) % 4)));
`ifdef CKE_SCHED_OVF_EN
         if (k == 2) chk("ovf_k2", 32'(ovf), 4'b1101);
         if (k == 3) chk("ovf_k3", 32'(ovf), 4'b1111);
`endif
      end
      for (int c = 0; c < 4; c++) cfg(c, 0, 1'b0);
      repeat (3) cyc(1'b0);
      chk("off_busy", 32'(busy), 0);
      chk("off_cke", 32'(cke_out), 0);
`ifdef CKE_SCHED_OVF_EN
      chk("ovf_sticky", 32'(ovf), 4'b1111);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
